// File: rtl/irq_event_latch.sv
// Peripheral interrupt source: synchronises raw events, latches them as sticky
// (or transparent level) pending bits with overrun tracking, and drives active-low IRQs.
module irq_event_latch #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cs_n,
  input  logic                phi2,
  input  logic                write_enable,
  input  logic [1:0]          address,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  input  logic [CHANNELS-1:0] event_in,
  output logic [CHANNELS-1:0] irq_sources_n,
  output logic                irq_any_n
);

  localparam logic [1:0] ADDR_PENDING  = 2'd0;
  localparam logic [1:0] ADDR_OVERRUN  = 2'd1;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd2;
  localparam logic [1:0] ADDR_MODE     = 2'd3;

  localparam int ARM_CLKS = SYNC_STAGES + 1;
  localparam int ARM_W    = $clog2(ARM_CLKS + 1);

  // ---------------------------------------------------------------------------
  // Bus capture and commit
  // ---------------------------------------------------------------------------
  logic       phi2_q;
  logic       cap_cs_n;
  logic       cap_we;
  logic [1:0] cap_addr;
  logic [7:0] cap_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phi2_q   <= 1'b0;
      cap_cs_n <= 1'b0;
      cap_we   <= 1'b0;
      cap_addr <= 2'd0;
      cap_data <= 8'd0;
    end else begin
      phi2_q <= phi2;
      if (phi2) begin
        cap_cs_n <= cs_n;
        cap_we   <= write_enable;
        cap_addr <= address;
        cap_data <= data_in;
      end
    end
  end

  // A write lands once, on the clk that first sees phi2 low after a high phase.
  logic                commit;
  logic                wr_pending;
  logic                wr_overrun;
  logic                wr_edge_sel;
  logic                wr_mode;
  logic [CHANNELS-1:0] wr_data;

  assign commit      = phi2_q & ~phi2 & ~cap_cs_n & cap_we;
  assign wr_pending  = commit && (cap_addr == ADDR_PENDING);
  assign wr_overrun  = commit && (cap_addr == ADDR_OVERRUN);
  assign wr_edge_sel = commit && (cap_addr == ADDR_EDGE_SEL);
  assign wr_mode     = commit && (cap_addr == ADDR_MODE);
  assign wr_data     = cap_data[CHANNELS-1:0];

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge history
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] hist_q;
  logic [CHANNELS-1:0] sync_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
      hist_q <= '0;
    end else begin
      sync_q[0] <= event_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Masks the synchroniser fill after reset so static inputs never look like edges.
  logic [ARM_W-1:0] arm_cnt;
  logic             armed;

  assign armed = (arm_cnt == ARM_W'(ARM_CLKS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt <= '0;
    end else if (!armed) begin
      arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] pending;
  logic [CHANNELS-1:0] overrun;
  logic [CHANNELS-1:0] edge_sel;
  logic [CHANNELS-1:0] mode;

  logic [CHANNELS-1:0] edge_ev;
  logic [CHANNELS-1:0] edge_hit;
  logic [CHANNELS-1:0] mode_chg;
  logic [CHANNELS-1:0] pend_clr;
  logic [CHANNELS-1:0] ovr_clr;
  logic [CHANNELS-1:0] ovr_new;
  logic [CHANNELS-1:0] edge_pend;
  logic [CHANNELS-1:0] level_pend;
  logic [CHANNELS-1:0] pending_d;
  logic [CHANNELS-1:0] overrun_d;
  logic [CHANNELS-1:0] edge_sel_d;
  logic [CHANNELS-1:0] mode_d;

  always_comb begin
    edge_ev    = '0;
    edge_hit   = '0;
    mode_chg   = '0;
    pend_clr   = '0;
    ovr_clr    = '0;
    ovr_new    = '0;
    edge_pend  = '0;
    level_pend = '0;
    pending_d  = pending;
    overrun_d  = overrun;
    edge_sel_d = edge_sel;
    mode_d     = mode;

    if (armed) begin
      edge_ev = (edge_sel & hist_q & ~sync_s) | (~edge_sel & sync_s & ~hist_q);
    end
    edge_hit = edge_ev & ~mode;

    if (wr_mode) begin
      mode_chg = wr_data ^ mode;
      mode_d   = wr_data;
    end
    if (wr_edge_sel) begin
      edge_sel_d = wr_data;
    end
    // Level-mode channels ignore PENDING W1C; OVERRUN W1C applies to all.
    if (wr_pending) begin
      pend_clr = wr_data & ~mode;
    end
    if (wr_overrun) begin
      ovr_clr = wr_data;
    end

    // An event always sets pending; it is an overrun only if no clear raced it.
    ovr_new    = edge_hit & pending & ~pend_clr;
    edge_pend  = edge_hit | (pending & ~pend_clr);
    level_pend = sync_s ^ edge_sel;

    pending_d = ((mode & level_pend) | (~mode & edge_pend)) & ~mode_chg;
    overrun_d = (ovr_new | (overrun & ~ovr_clr)) & ~mode_chg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= '0;
      overrun  <= '0;
      edge_sel <= '0;
      mode     <= '0;
    end else begin
      pending  <= pending_d;
      overrun  <= overrun_d;
      edge_sel <= edge_sel_d;
      mode     <= mode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out = 8'd0;
    case (address)
      ADDR_PENDING:  data_out[CHANNELS-1:0] = pending;
      ADDR_OVERRUN:  data_out[CHANNELS-1:0] = overrun;
      ADDR_EDGE_SEL: data_out[CHANNELS-1:0] = edge_sel;
      ADDR_MODE:     data_out[CHANNELS-1:0] = mode;
      default:       data_out = 8'd0;
    endcase
  end

  assign irq_sources_n = ~pending;
  assign irq_any_n     = ~|pending;

endmodule

// File: tb/tb_irq_event_latch.sv
// Bench for irq_event_latch: directed vector table, hand-timed corner sequences,
// and randomized traffic checked every cycle against a history-based reference model.
module tb_irq_event_latch;

  localparam int SYNC = 2;

  localparam int OP_EV = 0;
  localparam int OP_WR = 1;
  localparam int OP_RD = 2;

  logic       clk;
  logic       reset_n;
  logic       cs_n;
  logic       phi2;
  logic       write_enable;
  logic [1:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] event_in;
  logic [7:0] irq_sources_n;
  logic       irq_any_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  irq_event_latch #(.CHANNELS(8), .SYNC_STAGES(SYNC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cs_n          (cs_n),
    .phi2          (phi2),
    .write_enable  (write_enable),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .event_in      (event_in),
    .irq_sources_n (irq_sources_n),
    .irq_any_n     (irq_any_n)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // s is event_in as sampled SYNC edges ago, p one edge older; events count
  // only once more than SYNC+1 edges have passed since reset.
  logic [7:0] m_pend, m_ovr, m_esel, m_mode;
  logic [7:0] n_pend, n_ovr;
  logic [7:0] ev_hist[$];
  logic [7:0] s_v, p_v;
  int         m_edges;
  logic       m_phi_prev, m_cap_cs_n, m_cap_we;
  logic [1:0] m_cap_addr;
  logic [7:0] m_cap_data;
  bit         m_commit, hit, w1c_p, w1c_o;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = 8'h00; m_ovr = 8'h00; m_esel = 8'h00; m_mode = 8'h00;
      ev_hist = {};
      for (int k = 0; k <= SYNC; k++) ev_hist.push_back(8'h00);
      m_edges = 0;
      m_phi_prev = 1'b0; m_cap_cs_n = 1'b1; m_cap_we = 1'b0;
      m_cap_addr = 2'd0; m_cap_data = 8'h00;
    end else begin
      m_edges++;
      s_v = ev_hist[SYNC-1];
      p_v = ev_hist[SYNC];
      m_commit = m_phi_prev && !phi2 && !m_cap_cs_n && m_cap_we;
      for (int i = 0; i < 8; i++) begin
        w1c_p = m_commit && (m_cap_addr == 2'd0) && m_cap_data[i];
        w1c_o = m_commit && (m_cap_addr == 2'd1) && m_cap_data[i];
        if (m_commit && (m_cap_addr == 2'd3) && (m_cap_data[i] != m_mode[i])) begin
          n_pend[i] = 1'b0; n_ovr[i] = 1'b0;
        end else if (m_mode[i]) begin
          n_pend[i] = s_v[i] ^ m_esel[i];
          n_ovr[i]  = w1c_o ? 1'b0 : m_ovr[i];
        end else begin
          hit = (m_edges > SYNC + 1) &&
                (m_esel[i] ? (p_v[i] && !s_v[i]) : (s_v[i] && !p_v[i]));
          if (hit && m_pend[i] && !w1c_p) begin
            n_pend[i] = 1'b1; n_ovr[i] = 1'b1;
          end else if (hit) begin
            n_pend[i] = 1'b1; n_ovr[i] = w1c_o ? 1'b0 : m_ovr[i];
          end else begin
            n_pend[i] = w1c_p ? 1'b0 : m_pend[i];
            n_ovr[i]  = w1c_o ? 1'b0 : m_ovr[i];
          end
        end
      end
      m_pend = n_pend;
      m_ovr  = n_ovr;
      if (m_commit && m_cap_addr == 2'd2) m_esel = m_cap_data;
      if (m_commit && m_cap_addr == 2'd3) m_mode = m_cap_data;
      if (phi2) begin
        m_cap_cs_n = cs_n; m_cap_we = write_enable;
        m_cap_addr = address; m_cap_data = data_in;
      end
      m_phi_prev = phi2;
      ev_hist.push_front(event_in);
      void'(ev_hist.pop_back());
    end
  end

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return m_pend;
      2'd1:    return m_ovr;
      2'd2:    return m_esel;
      default: return m_mode;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      #2;
      check("model_data_out", data_out, exp_rd(address));
      check("model_irq_sources_n", irq_sources_n, ~m_pend);
      check("model_irq_any_n", {7'd0, irq_any_n}, {7'd0, (m_pend == 8'h00)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input logic csn);
    @(negedge clk);
    cs_n = csn; write_enable = 1'b1; address = a; data_in = d; phi2 = 1'b1;
    @(negedge clk);
    phi2 = 1'b0; cs_n = 1'b1; write_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a,
                          input logic [7:0] exp_d, input logic [7:0] exp_irq);
    @(negedge clk);
    address = a;
    #2;
    check({name, "_data"}, data_out, exp_d);
    check({name, "_irq_n"}, irq_sources_n, exp_irq);
    check({name, "_any_n"}, {7'd0, irq_any_n}, (exp_irq == 8'hFF) ? 8'd1 : 8'd0);
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk); event_in = v;
    @(negedge clk);
    @(negedge clk); event_in = 8'h00;
    repeat (5) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         op;
    logic [7:0] ev;
    logic [1:0] addr;
    logic [7:0] data;
    int         n;
    logic [7:0] exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int op, input logic [7:0] ev, input logic [1:0] a,
                              input logic [7:0] d, input int n, input logic [7:0] irq);
    vec_t v;
    v.op = op; v.ev = ev; v.addr = a; v.data = d; v.n = n; v.exp_irq = irq;
    tbl.push_back(v);
  endfunction

  function automatic void ev(input logic [7:0] v, input int n);
    add(OP_EV, v, 2'd0, 8'h00, n, 8'hFF);
  endfunction
  function automatic void wr(input logic [1:0] a, input logic [7:0] d);
    add(OP_WR, 8'h00, a, d, 1, 8'hFF);
  endfunction
  function automatic void rd(input logic [1:0] a, input logic [7:0] d, input logic [7:0] irq);
    add(OP_RD, 8'h00, a, d, 1, irq);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; cs_n = 1'b1; phi2 = 1'b0; write_enable = 1'b0;
    address = 2'd0; data_in = 8'h00; event_in = 8'hFF;

    // two pulses on ch0, overrun W1C leaves pending
    ev(8'h00, 6); rd(2'd0, 8'h00, 8'hFF);
    ev(8'h01, 2); ev(8'h00, 2); ev(8'h01, 2); ev(8'h00, 6);
    rd(2'd0, 8'h01, 8'hFE); rd(2'd1, 8'h01, 8'hFE);
    wr(2'd1, 8'h01); rd(2'd1, 8'h00, 8'hFE); rd(2'd0, 8'h01, 8'hFE);
    wr(2'd0, 8'h01); rd(2'd0, 8'h00, 8'hFF);
    // ch1 level mode, active low
    wr(2'd2, 8'h02); wr(2'd3, 8'h02); ev(8'h00, 5); rd(2'd0, 8'h02, 8'hFD);
    wr(2'd0, 8'h02); rd(2'd0, 8'h02, 8'hFD);
    ev(8'h02, 5); rd(2'd0, 8'h00, 8'hFF); rd(2'd2, 8'h02, 8'hFF); rd(2'd3, 8'h02, 8'hFF);
    // back to edge mode; polarity change alone creates no event
    wr(2'd3, 8'h00); wr(2'd2, 8'h00); rd(2'd0, 8'h00, 8'hFF);
    wr(2'd2, 8'h02); rd(2'd0, 8'h00, 8'hFF);
    ev(8'h00, 5); rd(2'd0, 8'h02, 8'hFD); wr(2'd0, 8'h02); rd(2'd0, 8'h00, 8'hFF);
    wr(2'd2, 8'h00);
    // MODE change clears pending and overrun
    ev(8'h01, 2); ev(8'h00, 2); ev(8'h01, 2); ev(8'h00, 6);
    rd(2'd0, 8'h01, 8'hFE); rd(2'd1, 8'h01, 8'hFE);
    wr(2'd3, 8'h01); rd(2'd0, 8'h00, 8'hFF); rd(2'd1, 8'h00, 8'hFF);
    wr(2'd3, 8'h00); rd(2'd3, 8'h00, 8'hFF);

    @(posedge clk);
    chk_en = 1'b1;

    // reset with all inputs high: no spurious events
    repeat (2) @(negedge clk);
    #2;
    check("rst_data", data_out, 8'h00);
    check("rst_irq_n", irq_sources_n, 8'hFF);
    check("rst_any_n", {7'd0, irq_any_n}, 8'd1);
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    rd_check("arm_pend", 2'd0, 8'h00, 8'hFF);
    rd_check("arm_ovr", 2'd1, 8'h00, 8'hFF);

    for (int k = 0; k < tbl.size(); k++) begin
      case (tbl[k].op)
        OP_EV: begin
          @(negedge clk); event_in = tbl[k].ev;
          repeat (tbl[k].n - 1) @(negedge clk);
        end
        OP_WR: bus_write(tbl[k].addr, tbl[k].data, 1'b0);
        default: rd_check($sformatf("tbl%0d", k), tbl[k].addr, tbl[k].data, tbl[k].exp_irq);
      endcase
    end

    // exact latency on ch3
    @(negedge clk); address = 2'd0; event_in = 8'h08;
    @(negedge clk); #2; check("lat_clk1", irq_sources_n, 8'hFF);
    @(negedge clk); event_in = 8'h00; #2; check("lat_clk2", irq_sources_n, 8'hFF);
    @(negedge clk); #2; check("lat_clk3", irq_sources_n, 8'hF7);
    check("lat_pend", data_out, 8'h08);
    bus_write(2'd0, 8'h08, 1'b0);
    rd_check("lat_clr", 2'd0, 8'h00, 8'hFF);

    // event on ch5 lands in the same clk as its W1C
    pulse(8'h20);
    rd_check("race_setup", 2'd0, 8'h20, 8'hDF);
    @(negedge clk); event_in = 8'h20;
    bus_write(2'd0, 8'h20, 1'b0);
    rd_check("race_pend", 2'd0, 8'h20, 8'hDF);
    rd_check("race_ovr", 2'd1, 8'h00, 8'hDF);
    @(negedge clk); event_in = 8'h00;
    bus_write(2'd0, 8'h20, 1'b0);
    rd_check("race_clr", 2'd0, 8'h00, 8'hFF);

    // deselected write, then one commit per phi2 fall with cs_n held low
    bus_write(2'd2, 8'hFF, 1'b1);
    rd_check("csn_hi", 2'd2, 8'h00, 8'hFF);
    pulse(8'h04);
    @(negedge clk);
    cs_n = 1'b0; write_enable = 1'b1; address = 2'd0; data_in = 8'h04; phi2 = 1'b1;
    repeat (3) @(negedge clk);
    #2; check("phi_hold", data_out, 8'h04);
    @(negedge clk); phi2 = 1'b0;
    @(negedge clk); #2; check("phi_fall1", data_out, 8'h00);
    @(negedge clk); event_in = 8'h04;
    repeat (2) @(negedge clk);
    event_in = 8'h00;
    repeat (6) @(negedge clk);
    #2; check("phi_once", data_out, 8'h04);
    @(negedge clk); phi2 = 1'b1;
    @(negedge clk); phi2 = 1'b0;
    @(negedge clk); #2; check("phi_fall2", data_out, 8'h00);
    cs_n = 1'b1; write_enable = 1'b0;

    // reset during a bus cycle drops the write and clears state
    pulse(8'h01);
    @(negedge clk);
    cs_n = 1'b0; write_enable = 1'b1; address = 2'd3; data_in = 8'hFF; phi2 = 1'b1;
    @(negedge clk); reset_n = 1'b0; #2;
    check("midrst_irq_n", irq_sources_n, 8'hFF);
    check("midrst_mode", data_out, 8'h00);
    @(negedge clk); reset_n = 1'b1; phi2 = 1'b0; cs_n = 1'b1; write_enable = 1'b0;
    rd_check("midrst_drop", 2'd3, 8'h00, 8'hFF);

    // randomized traffic, checked every cycle by the model
    @(negedge clk); reset_n = 1'b0; event_in = 8'($urandom);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus_write(2'($urandom_range(0, 3)), 8'($urandom), ($urandom_range(0, 7) == 0));
      end else begin
        @(negedge clk);
        event_in = event_in ^ 8'($urandom & $urandom & $urandom);
        address  = 2'($urandom_range(0, 3));
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
